wormhole_output_arbiter: RTL and testbench

WORMHOLE_OUTPUT_ARBITER -- requirements
Module: wormhole_output_arbiter

---
 rtl/wormhole_output_arbiter_pkg.sv | 13 +
 rtl/wormhole_output_arbiter_if.sv | 28 ++
 rtl/wormhole_output_arbiter_rr_picker.sv | 28 ++
 rtl/wormhole_output_arbiter.sv | 110 +++++++++++
 tb/tb_wormhole_output_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/wormhole_output_arbiter_pkg.sv
// Shared NoC types: the per-output arbiter state and the crossbar port-count constant.
package noc_types;

  localparam int NOC_PORTS = 4;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // Index width that stays legal for a single-port crossbar.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wormhole_output_arbiter_if.sv
// Handshake bundle between one crossbar output and its wormhole arbiter.
interface wormhole_output_arbiter_if
  import noc_types::*;
#(
  parameter int PORTS = NOC_PORTS
) ();

  localparam int IDX_W = idx_w(PORTS);

  logic [PORTS-1:0] req;
  logic             xfer;
  logic             tail;
  logic [PORTS-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             locked;
  logic             timeout;

  modport master (
    output req, xfer, tail,
    input  gnt, gnt_idx, locked, timeout
  );

  modport slave (
    input  req, xfer, tail,
    output gnt, gnt_idx, locked, timeout
  );

endinterface

// File: rtl/wormhole_output_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit scanning from ptr upward, modulo PORTS.
module rr_picker #(
  parameter int PORTS = 4,
  parameter int IDX_W = 2
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest-to-ptr request is written last and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = PORTS - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(ptr) + off) % PORTS);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wormhole_output_arbiter.sv
// Wormhole output arbiter: locks one input onto this output from header to tail, with idle watchdog.
module wormhole_output_arbiter
  import noc_types::*;
#(
  parameter int PORTS   = NOC_PORTS,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  wormhole_output_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_w(PORTS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PORTS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] ptr_after;
  logic             wd_fire;

  rr_picker #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign ptr_after = (gnt_idx_q == IDX_W'(PORTS - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
  assign wd_fire   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    locked_d  = locked_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = LOCKED;
          gnt_d     = PORTS'(1) << pick_idx;
          gnt_idx_d = pick_idx;
          locked_d  = 1'b1;
          cnt_d     = '0;
        end else begin
          gnt_d     = '0;
          gnt_idx_d = '0;
          locked_d  = 1'b0;
        end
      end
      LOCKED: begin
        // A tail always takes priority, so a coincident watchdog never raises timeout.
        if ((bus.xfer && bus.tail) || (!bus.xfer && wd_fire)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          locked_d  = 1'b0;
          ptr_d     = ptr_after;
          cnt_d     = '0;
          timeout_d = !bus.xfer;
        end else if (bus.xfer) begin
          cnt_d = '0;
        end else if (TIMEOUT != 0 && cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.locked  = locked_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Directed bench: one arbiter with the default watchdog, one with TIMEOUT=4.
module tb_wormhole_output_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wormhole_output_arbiter_if #(.PORTS(4)) ia ();
  wormhole_output_arbiter_if #(.PORTS(4)) ib ();

  wormhole_output_arbiter #(.PORTS(4), .TIMEOUT(255)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  wormhole_output_arbiter #(.PORTS(4), .TIMEOUT(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ia.req = '0; ia.xfer = 1'b0; ia.tail = 1'b0;
    ib.req = '0; ib.xfer = 1'b0; ib.tail = 1'b0;

    // Reset state
    #3;
    chk("rst_gnt_a", 32'(ia.gnt), 32'h0);
    chk("rst_idx_a", 32'(ia.gnt_idx), 32'h0);
    chk("rst_lock_a", 32'(ia.locked), 32'h0);
    chk("rst_to_a", 32'(ia.timeout), 32'h0);
    chk("rst_gnt_b", 32'(ib.gnt), 32'h0);
    #4;
    rst = 1'b1;

    // Basic grant
    ia.req = 4'b1010;
    tick();
    chk("grant1_gnt", 32'(ia.gnt), 32'h2);
    chk("grant1_idx", 32'(ia.gnt_idx), 32'h1);
    chk("grant1_lock", 32'(ia.locked), 32'h1);

    // Three body flits keep the lock
    ia.xfer = 1'b1; ia.tail = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("body_gnt", 32'(ia.gnt), 32'h2);
    end

    // Tail releases; one bubble; round robin continues at 3 then 0
    ia.tail = 1'b1; ia.req = 4'b1011;
    tick();
    chk("tail_gnt", 32'(ia.gnt), 32'h0);
    chk("tail_lock", 32'(ia.locked), 32'h0);
    chk("tail_idx", 32'(ia.gnt_idx), 32'h0);
    ia.xfer = 1'b0; ia.tail = 1'b0;
    tick();
    chk("rr3_gnt", 32'(ia.gnt), 32'h8);
    chk("rr3_idx", 32'(ia.gnt_idx), 32'h3);
    ia.xfer = 1'b1; ia.tail = 1'b1;
    tick();
    chk("rr3_rel", 32'(ia.gnt), 32'h0);
    ia.xfer = 1'b0; ia.tail = 1'b0;
    tick();
    chk("rr0_gnt", 32'(ia.gnt), 32'h1);
    chk("rr0_idx", 32'(ia.gnt_idx), 32'h0);

    // Winner drops req, others request: lock holds
    ia.req = 4'b1110;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_gnt", 32'(ia.gnt), 32'h1);
    end
    chk("hold_lock", 32'(ia.locked), 32'h1);
    chk("hold_to", 32'(ia.timeout), 32'h0);

    ia.xfer = 1'b1; ia.tail = 1'b1;
    tick();
    chk("hold_rel", 32'(ia.gnt), 32'h0);
    ia.xfer = 1'b0; ia.tail = 1'b0;
    tick();
    chk("rr1_gnt", 32'(ia.gnt), 32'h2);
    ia.xfer = 1'b1;
    tick();
    ia.xfer = 1'b0;

    // Asynchronous reset mid-packet
    #2;
    rst = 1'b0;
    #1;
    chk("arst_gnt_a", 32'(ia.gnt), 32'h0);
    chk("arst_lock_a", 32'(ia.locked), 32'h0);
    chk("arst_idx_a", 32'(ia.gnt_idx), 32'h0);
    ia.req = 4'b1111;
    #2;
    rst = 1'b1;
    tick();
    chk("arst_first_gnt", 32'(ia.gnt), 32'h1);
    chk("arst_first_idx", 32'(ia.gnt_idx), 32'h0);
    ia.req = '0; ia.xfer = 1'b1; ia.tail = 1'b1;
    tick();
    ia.xfer = 1'b0; ia.tail = 1'b0;
    chk("a_idle_lock", 32'(ia.locked), 32'h0);

    // Watchdog with TIMEOUT=4
    ib.req = 4'b0100;
    tick();
    chk("wd_grant", 32'(ib.gnt), 32'h4);
    ib.req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_wait_lock", 32'(ib.locked), 32'h1);
      chk("wd_wait_to", 32'(ib.timeout), 32'h0);
    end
    tick();
    chk("wd_fire_to", 32'(ib.timeout), 32'h1);
    chk("wd_fire_lock", 32'(ib.locked), 32'h0);
    chk("wd_fire_gnt", 32'(ib.gnt), 32'h0);
    ib.req = 4'b1001;
    tick();
    chk("wd_pulse_end", 32'(ib.timeout), 32'h0);
    chk("wd_ptr_gnt", 32'(ib.gnt), 32'h8);
    chk("wd_ptr_idx", 32'(ib.gnt_idx), 32'h3);

    // Tail on the exact watchdog cycle
    ib.req = '0;
    for (int i = 0; i < 3; i++) tick();
    chk("tie_pre_lock", 32'(ib.locked), 32'h1);
    ib.xfer = 1'b1; ib.tail = 1'b1;
    tick();
    chk("tie_to", 32'(ib.timeout), 32'h0);
    chk("tie_lock", 32'(ib.locked), 32'h0);
    chk("tie_gnt", 32'(ib.gnt), 32'h0);

    // Body flit clears the watchdog counter
    ib.xfer = 1'b0; ib.tail = 1'b0; ib.req = 4'b0010;
    tick();
    chk("clr_grant", 32'(ib.gnt), 32'h2);
    ib.req = '0;
    tick();
    tick();
    ib.xfer = 1'b1;
    tick();
    ib.xfer = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("clr_lock", 32'(ib.locked), 32'h1);
    chk("clr_to0", 32'(ib.timeout), 32'h0);
    tick();
    chk("clr_to1", 32'(ib.timeout), 32'h1);
    chk("clr_rel", 32'(ib.locked), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
